// File: rtl/regs_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
// Helpers size addresses and range-check register indices.
package regs_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ADDR_W_MAX = 5;
  localparam int REG_ZERO = 0;

  typedef logic [ADDR_W_MAX-1:0] reg_addr_t;

  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic in_range(
    input int unsigned a,
    input int unsigned n
  );
    return a < n;
  endfunction

endpackage

// File: rtl/regs_scoreboard.sv
// Per-register busy bits: set by issue, cleared by writeback, set wins.
// busy_nxt exposes the post-edge state for same-edge hazard sampling.
module regs_scoreboard
  import regs_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [NUM_REGS-1:0] busy_nxt
);

  logic [NUM_REGS-1:0] busy_q;

  always_comb begin
    busy_nxt = busy_q;
    if (clr_en && in_range(32'(clr_addr), NUM_REGS))
      busy_nxt[clr_addr] = 1'b0;
    if (set_en && in_range(32'(set_addr), NUM_REGS))
      busy_nxt[set_addr] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regs_mp.sv
// Multi-port integer register file with busy scoreboard; x0 reads zero.
// Define REGFILE_BYPASS_EN for write-first same-edge forwarding.
module regs_mp
  import regs_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD_PORTS = 2,
  localparam int ADDR_W = addr_w(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rs_rd_en,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0] rs_addr,
  output logic [NUM_RD_PORTS*XLEN-1:0]   rs_rd_data,
  output logic [NUM_RD_PORTS-1:0]        rs_busy,
  input  logic [ADDR_W-1:0]              rd,
  input  logic [XLEN-1:0]                rd_wr_data,
  input  logic                           rd_wr_en,
  input  logic                           issue_en,
  input  logic [ADDR_W-1:0]              issue_rd,
  output logic [NUM_REGS-1:0]            busy_vec
);

  function automatic logic live(input logic [ADDR_W-1:0] a);
    return (a != ADDR_W'(REG_ZERO)) &&
           in_range(32'(a), NUM_REGS);
  endfunction

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic                wr_hit;
  logic [NUM_REGS-1:0] busy_nxt;

  assign wr_hit = rd_wr_en && live(rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[rd] <= rd_wr_data;
    end
  end

  regs_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue_en),
    .set_addr(issue_rd),
    .clr_en  (rd_wr_en),
    .clr_addr(rd),
    .busy_vec(busy_vec),
    .busy_nxt(busy_nxt)
  );

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [XLEN-1:0]   d_nxt;
    logic [XLEN-1:0]   d_q;
    logic              b_q;

    assign a = rs_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      d_nxt = '0;
      if (live(a)) begin
        d_nxt = regs[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && rd == a) d_nxt = rd_wr_data;
`endif
      end
    end

    // busy sampled from post-edge scoreboard so decode never sees stale hazards
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        d_q <= '0;
        b_q <= 1'b0;
      end else if (rs_rd_en) begin
        d_q <= d_nxt;
        b_q <= live(a) && busy_nxt[a];
      end
    end

    assign rs_rd_data[p*XLEN +: XLEN] = d_q;
    assign rs_busy[p] = b_q;
  end

endmodule
